alu_issuer: RTL and testbench
=============================

# alu_issuer

Sequencing front end that drives the `alu` execution block. It accepts one operation at a time over a valid/ready command channel and presents opcode, funct and operands to the ALU. It waits for the ALU's `valid_o`, which arrives in the same cycle for combinational units and later for the shift unit. It then returns result, overflow, tag and error status over a valid/ready response channel, with illegal-opcode rejection and a watchdog timeout.

## Interface
- `TAG_W`, 4: width of the command/response tag.
- `TIMEOUT`, 64: cycles allowed in WAIT before a timeout error is reported; legal range 1 to 255.
- `clk` input 1: clock; all state changes on its rising edge.
- `rst_n` input 1: reset; one clock, asynchronous assert, active-low.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: issuer can accept a command.
- `cmd_opcode` input 4: ALU opcode.
- `cmd_funct` input 3: ALU funct.
- `cmd_a` input 32: operand A.
- `cmd_b` input 32: operand B.
- `cmd_tag` input TAG_W: returned unchanged with the response.
- `alu_valid_i` output 1: start strobe to the ALU `valid_i`.
- `alu_opcode` output 4: to the ALU `opcode`.
- `alu_funct` output 3: to the ALU `funct`.
- `alu_a` output 32: to the ALU operand `a`.
- `alu_b` output 32: to the ALU operand `b`.
- `alu_o` input 32: ALU result.
- `alu_valid_o` input 1: ALU result valid.
- `alu_overflow` input 1: ALU arithmetic overflow.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_data` output 32: result.
- `rsp_overflow` output 1: overflow flag; meaningful only for opcode 4'b0000.
- `rsp_err` output 1: illegal opcode or timeout.
- `rsp_tag` output TAG_W: tag of the completed command.
- `done_cnt` output 16: saturating count of responses accepted with `rsp_err`=0.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`, latch opcode, funct, a, b and tag into holding registers.
  - If opcode > 4'b1010, go to RESP with `rsp_err`=1, `rsp_data`=32'hDEADBEEF and `rsp_overflow`=0. No ALU strobe is issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - `alu_valid_i`=1 for exactly this one cycle.
  - If `alu_valid_o`=1 in this cycle, capture `alu_o` and go to RESP.
  - Otherwise go to WAIT and clear the timeout counter.
- WAIT:
  - `alu_valid_i`=0; the counter increments each cycle.
  - On `alu_valid_o`=1, capture the result and go to RESP.
  - If the counter reaches TIMEOUT-1 with no `alu_valid_o`, go to RESP with `rsp_err`=1 and `rsp_data`=0.
  - If `alu_valid_o` and the timeout occur in the same cycle, the result wins and `rsp_err`=0.
- Capture rule: `rsp_overflow` = `alu_overflow` only when the latched opcode is 4'b0000; otherwise 0.
- RESP:
  - `rsp_valid`=1 and all `rsp_*` outputs are held stable until `rsp_ready`.
  - On handshake, go to IDLE.
  - `done_cnt` increments on the handshake if `rsp_err`=0; it saturates at 16'hFFFF.
- `alu_valid_o` arriving in RESP or IDLE is a late result and is ignored.
- `alu_opcode`, `alu_funct`, `alu_a` and `alu_b` always drive the holding registers. They stay constant from ISSUE until the FSM leaves RESP.
- Only one command is in flight at a time; there is no queueing.

## Timing
- Reset values:
  - State IDLE.
  - `cmd_ready`=0 while `rst_n`=0, and 1 in the first cycle after release.
  - `alu_valid_i`=0.
  - `alu_opcode`, `alu_funct`, `alu_a`, `alu_b` = 0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_overflow`=0, `rsp_err`=0, `rsp_tag`=0.
  - `done_cnt`=0.
- Reset asserted mid-operation abandons the command with no response. The block is in IDLE after release.
- Combinational ALU op: accept in cycle N, `alu_valid_i` in N+1, `rsp_valid` from N+2.
- Multi-cycle op whose `alu_valid_o` arrives k cycles after the strobe: `rsp_valid` at N+2+k.
- Illegal opcode: `rsp_valid` at N+1.
- Timeout: `rsp_valid` at N+2+TIMEOUT.
- Back-to-back throughput:
  - `cmd_ready` returns the cycle after the response handshake.
  - Minimum 3 cycles per combinational op when `rsp_ready` is held 1.
- `cmd_ready` is never combinationally dependent on `rsp_ready`.

## Test plan
- Add, combinational: a=32'h7FFFFFFF, b=1, opcode 0000, tag 3, `rsp_ready`=1.
  - Required: `rsp_valid` at N+2 with `rsp_overflow` and `rsp_tag` = 3.
  - Required: `rsp_data` equals the `alu_o` captured in the ISSUE cycle.
- Shift with `alu_valid_o` delayed 5 cycles.
  - Required: `rsp_valid` at N+7.
  - Required: `alu_a`/`alu_b` stable throughout, `alu_valid_i` high for exactly one cycle.
- Opcode 4'b1100.
  - Required: `rsp_valid` at N+1 with `rsp_err`=1 and `rsp_data`=32'hDEADBEEF.
  - Required: no `alu_valid_i` pulse; `done_cnt` unchanged.
- Timeout, TIMEOUT=4, ALU never responds.
  - Required: `rsp_err`=1 and `rsp_data`=0 at N+6.
  - Then drive a late `alu_valid_o` in IDLE; required: it is ignored and no second response appears.
- Backpressure: `rsp_ready`=0 for 10 cycles with a second `cmd_valid` pending.
  - Required: response fields stable and `cmd_ready`=0 throughout.
  - Required: the second command is accepted the cycle after the handshake.
- Reset pulse while in WAIT.
  - Required: all outputs return immediately to their reset values; `rsp_valid` never asserts.
  - Required: `cmd_ready`=1 in the cycle after `rst_n` rises.

Source files
------------

// File: rtl/alu_issuer.sv
// alu_issuer: single-outstanding command sequencer in front of the alu block.
// Accepts one command, strobes the ALU once, and waits for its result or a
// watchdog timeout. The outcome is held on the response channel until the
// consumer accepts it. Illegal opcodes are answered directly, without touching
// the ALU.
module alu_issuer #(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    // command channel
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [2:0]       cmd_funct,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    // ALU side
    output logic             alu_valid_i,
    output logic [3:0]       alu_opcode,
    output logic [2:0]       alu_funct,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_o,
    input  logic             alu_valid_o,
    input  logic             alu_overflow,
    // response channel
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_overflow,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [15:0]      done_cnt
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_ISSUE = 2'd1;
    localparam logic [1:0]  S_WAIT  = 2'd2;
    localparam logic [1:0]  S_RESP  = 2'd3;

    localparam logic [3:0]  OP_MAX    = 4'b1010;
    localparam logic [31:0] ILL_DATA  = 32'hDEADBEEF;
    localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_cmd_ready;

    // holding registers for the command in flight
    logic [3:0]       r_opcode;
    logic [2:0]       r_funct;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [TAG_W-1:0] r_tag;

    logic [7:0]       r_wait_cnt;

    logic [31:0]      r_rsp_data;
    logic             r_rsp_overflow;
    logic             r_rsp_err;
    logic [TAG_W-1:0] r_rsp_tag;
    logic [15:0]      r_done_cnt;

    logic             w_accept;
    logic             w_illegal;
    logic             w_capture;
    logic             w_timeout;
    logic             w_rsp_hs;

    // r_cmd_ready is only ever 1 while r_state is IDLE, so it alone qualifies acceptance
    assign w_accept  = cmd_valid & r_cmd_ready;
    assign w_illegal = (cmd_opcode > OP_MAX);
    // a result in ISSUE or WAIT is taken; anything arriving in IDLE/RESP is stale
    assign w_capture = ((r_state == S_ISSUE) || (r_state == S_WAIT)) && alu_valid_o;
    assign w_timeout = (r_state == S_WAIT) && (r_wait_cnt == WAIT_LAST);
    assign w_rsp_hs  = (r_state == S_RESP) && rsp_ready;

    // next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = w_illegal ? S_RESP : S_ISSUE;
            S_ISSUE: w_next_state = alu_valid_o ? S_RESP : S_WAIT;
            S_WAIT:  if (alu_valid_o || w_timeout) w_next_state = S_RESP;
            S_RESP:  if (rsp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // state register; cmd_ready is registered so it never follows rsp_ready combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cmd_ready <= (w_next_state == S_IDLE);
        end
    end

    // latch the accepted command; it stays put until the next acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode <= '0;
            r_funct  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_tag    <= '0;
        end else if (w_accept) begin
            r_opcode <= cmd_opcode;
            r_funct  <= cmd_funct;
            r_a      <= cmd_a;
            r_b      <= cmd_b;
            r_tag    <= cmd_tag;
        end
    end

    // watchdog: zero on the strobe cycle, counts every WAIT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    // response fields load only on entry to RESP, so they are frozen while presented
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data     <= '0;
            r_rsp_overflow <= 1'b0;
            r_rsp_err      <= 1'b0;
            r_rsp_tag      <= '0;
        end else if ((r_state == S_IDLE) && w_accept && w_illegal) begin
            r_rsp_data     <= ILL_DATA;
            r_rsp_overflow <= 1'b0;
            r_rsp_err      <= 1'b1;
            r_rsp_tag      <= cmd_tag;
        end else if (w_capture) begin
            // result beats a simultaneous timeout
            r_rsp_data     <= alu_o;
            r_rsp_overflow <= (r_opcode == 4'b0000) && alu_overflow;
            r_rsp_err      <= 1'b0;
            r_rsp_tag      <= r_tag;
        end else if (w_timeout) begin
            r_rsp_data     <= '0;
            r_rsp_overflow <= 1'b0;
            r_rsp_err      <= 1'b1;
            r_rsp_tag      <= r_tag;
        end
    end

    // saturating count of error-free responses taken by the consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_cnt <= '0;
        end else if (w_rsp_hs && !r_rsp_err && (r_done_cnt != 16'hFFFF)) begin
            r_done_cnt <= r_done_cnt + 16'd1;
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign alu_valid_i  = (r_state == S_ISSUE);
    assign alu_opcode   = r_opcode;
    assign alu_funct    = r_funct;
    assign alu_a        = r_a;
    assign alu_b        = r_b;
    assign rsp_valid    = (r_state == S_RESP);
    assign rsp_data     = r_rsp_data;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_err      = r_rsp_err;
    assign rsp_tag      = r_rsp_tag;
    assign done_cnt     = r_done_cnt;

endmodule

// File: tb/tb_alu_issuer.sv
// Self-checking bench for alu_issuer. The bench plays the ALU (result delay k
// cycles after the strobe, k=0 meaning same cycle) and predicts each response
// from the command, the delay and the timeout rule.
module tb_alu_issuer;
    localparam int TAG_W = 4;
    localparam int TO    = 8;
    localparam int NEVER = 1000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_opcode;
    logic [2:0]       cmd_funct;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [TAG_W-1:0] cmd_tag;
    logic             alu_valid_i;
    logic [3:0]       alu_opcode;
    logic [2:0]       alu_funct;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [31:0]      alu_o;
    logic             alu_valid_o;
    logic             alu_overflow;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_overflow;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;
    logic [15:0]      done_cnt;

    int n_tests  = 0;
    int n_fail   = 0;
    int exp_done = 0;

    always #5 clk = ~clk;

    alu_issuer #(.TAG_W(TAG_W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_funct(cmd_funct), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_valid_i(alu_valid_i), .alu_opcode(alu_opcode), .alu_funct(alu_funct),
        .alu_a(alu_a), .alu_b(alu_b), .alu_o(alu_o), .alu_valid_o(alu_valid_o),
        .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_overflow(rsp_overflow), .rsp_err(rsp_err), .rsp_tag(rsp_tag),
        .done_cnt(done_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Issue one command at a negedge where the issuer should be idle, play the
    // ALU, check the response, optionally stall the consumer for 'hold' cycles
    // (with a second command pending if 'pend'), then hand the response off.
    task automatic run_cmd(input logic [3:0] op, input logic [2:0] fn,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] tag, input int k,
                           input logic [31:0] res, input logic ovf,
                           input int hold, input bit pend);
        bit          illegal, won;
        int          exp_lat, lat, strobes, bad;
        logic [31:0] s_data;
        logic        s_ovf, s_err;
        logic [3:0]  s_tag;
        illegal = (op > 4'd10);
        won     = !illegal && (k <= TO);
        exp_lat = illegal ? 1 : (won ? 2 + k : 2 + TO);
        lat = 0; strobes = 0; bad = 0;

        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_opcode = op; cmd_funct = fn;
        cmd_a = a; cmd_b = b; cmd_tag = tag;
        rsp_ready = (hold == 0);
        @(negedge clk);
        cmd_valid = 1'b0;

        for (int c = 1; c <= TO + 6 && lat == 0; c++) begin
            if (alu_valid_i) strobes++;
            if (alu_opcode !== op || alu_funct !== fn || alu_a !== a ||
                alu_b !== b || cmd_ready !== 1'b0) bad++;
            if (rsp_valid) begin
                lat = c;
            end else begin
                if (c - 1 == k) begin
                    alu_valid_o = 1'b1; alu_o = res; alu_overflow = ovf;
                end
                @(negedge clk);
                alu_valid_o = 1'b0; alu_o = $urandom; alu_overflow = 1'($urandom_range(0, 1));
            end
        end

        chk("rsp_latency", lat, exp_lat);
        if (lat == 0) begin
            rsp_ready = 1'b1;
            return;
        end
        chk("alu_strobes", strobes, illegal ? 0 : 1);
        chk("rsp_err", rsp_err, !won);
        chk("rsp_data", rsp_data, illegal ? 32'hDEADBEEF : (won ? res : 32'h0));
        chk("rsp_overflow", rsp_overflow, won && (op == 4'd0) && ovf);
        chk("rsp_tag", rsp_tag, tag);

        s_data = rsp_data; s_ovf = rsp_overflow; s_err = rsp_err; s_tag = rsp_tag;
        for (int h = 0; h < hold; h++) begin
            if (pend) cmd_valid = 1'b1;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== s_data || rsp_overflow !== s_ovf ||
                rsp_err !== s_err || rsp_tag !== s_tag || cmd_ready !== 1'b0 ||
                alu_valid_i !== 1'b0 || alu_a !== a || alu_b !== b) bad++;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        if (won) exp_done++;
        chk("alu_stable", bad, 0);
        chk("rsp_drop", rsp_valid, 0);
        chk("cmd_ready_after", cmd_ready, 1);
        chk("done_cnt", done_cnt, exp_done);
        if (!pend) cmd_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_alu_valid_i"}, alu_valid_i, 0);
        chk({tag, "_alu_fields"}, {alu_opcode, alu_funct, 25'd0} | alu_a | alu_b, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_flags"}, {rsp_overflow, rsp_err, rsp_tag}, 0);
        chk({tag, "_done_cnt"}, done_cnt, 0);
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_funct = '0;
        cmd_a = '0; cmd_b = '0; cmd_tag = '0; alu_o = '0; alu_valid_o = 1'b0;
        alu_overflow = 1'b0; rsp_ready = 1'b0;

        @(negedge clk);
        chk_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // signed add overflow, combinational
        run_cmd(4'b0000, 3'd0, 32'h7FFFFFFF, 32'h1, 4'd3, 0, 32'h80000000, 1'b1, 0, 0);
        // overflow reported by ALU on a non-add opcode must be masked
        run_cmd(4'b0011, 3'd2, 32'h1234, 32'h5678, 4'd9, 0, 32'hCAFE0000, 1'b1, 0, 0);
        // shift, result 5 cycles after strobe
        run_cmd(4'b0111, 3'd1, 32'hA5A5A5A5, 32'd4, 4'd7, 5, 32'h5A5A5A50, 1'b0, 0, 0);
        // illegal opcode
        run_cmd(4'b1100, 3'd0, 32'h1, 32'h2, 4'd5, 0, 32'h0, 1'b0, 0, 0);
        // highest legal opcode
        run_cmd(4'b1010, 3'd3, 32'h3, 32'h4, 4'd6, 0, 32'h77, 1'b0, 0, 0);
        // timeout, ALU never answers
        run_cmd(4'b0111, 3'd0, 32'h11, 32'h22, 4'd1, NEVER, 32'h0, 1'b0, 0, 0);
        // late result in IDLE must be ignored
        alu_valid_o = 1'b1; alu_o = 32'h0BAD0BAD;
        @(negedge clk);
        alu_valid_o = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad++;
            @(negedge clk);
        end
        chk("late_ignored", bad, 0);
        chk("late_done_cnt", done_cnt, exp_done);
        // result and timeout in the same cycle: result wins
        run_cmd(4'b0000, 3'd0, 32'h2, 32'h3, 4'd2, TO, 32'h5, 1'b1, 0, 0);
        // backpressure with a second command pending, then immediate accept
        run_cmd(4'b0001, 3'd0, 32'hF0F0F0F0, 32'h0F0F0F0F, 4'd4, 0, 32'h12345678, 1'b0, 10, 1);
        run_cmd(4'b0010, 3'd4, 32'h9, 32'h8, 4'd8, 0, 32'h1, 1'b0, 0, 0);
        // back-to-back combinational ops
        run_cmd(4'b0000, 3'd0, 32'h10, 32'h20, 4'd10, 0, 32'h30, 1'b0, 0, 0);
        run_cmd(4'b0000, 3'd0, 32'h40, 32'h50, 4'd11, 0, 32'h90, 1'b0, 0, 0);

        // reset while in WAIT
        chk("rst_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_opcode = 4'b0111; cmd_funct = 3'd5;
        cmd_a = 32'hDEAD0001; cmd_b = 32'hBEEF0002; cmd_tag = 4'd12; rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_no_rsp", rsp_valid, 0);
        rst_n = 1'b0;
        #1;
        exp_done = 0;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", cmd_ready, 1);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("rst_no_rsp", bad, 0);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            int sel, k;
            sel = $urandom_range(0, 9);
            if (sel < 5)       k = 0;
            else if (sel < 7)  k = $urandom_range(1, TO - 1);
            else if (sel == 7) k = TO;
            else if (sel == 8) k = TO + 1;
            else               k = NEVER;
            run_cmd(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                    4'($urandom_range(0, 15)), k, $urandom, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
